// File: rtl/match_controller.sv
// Head-soccer game-flow sequencer: match state machine, match clock, kickoff
// countdown and score registers, all advancing once per video frame.
module match_controller #(
  parameter int          FRAMES_PER_SEC    = 60,
  parameter int          MATCH_SECONDS     = 90,
  parameter int          KICKOFF_SECONDS   = 3,
  parameter int          GOAL_PAUSE_FRAMES = 120,
  parameter int          WIN_SCORE         = 5,
  parameter logic [7:0]  START_KEY         = 8'h28
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic        goal_left,
  input  logic        goal_right,
  output logic        char_reset,
  output logic        ball_reset,
  output logic        play_en,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic [7:0]  time_left,
  output logic [1:0]  countdown,
  output logic [2:0]  state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_KICKOFF = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_GOAL    = 3'd3;
  localparam logic [2:0] S_OVER    = 3'd4;

  localparam int FC_W = ($clog2(FRAMES_PER_SEC) > 6) ? $clog2(FRAMES_PER_SEC) : 6;
  localparam int PC_W = ($clog2(GOAL_PAUSE_FRAMES) > 1) ? $clog2(GOAL_PAUSE_FRAMES) : 1;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? 4'hF : s + 4'd1;
  endfunction

  function automatic logic [7:0] floor_dec(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  logic            start_prev;
  logic            start_hit;
  logic            start_edge;
  logic [FC_W-1:0] frame_cnt;
  logic [PC_W-1:0] pause_cnt;
  logic            frame_wrap;
  logic            pause_done;
  logic            win_reached;

  logic [2:0]      nxt_state;
  logic [3:0]      nxt_p1;
  logic [3:0]      nxt_p2;
  logic [7:0]      nxt_time;
  logic [7:0]      dec_time;
  logic [1:0]      nxt_cd;
  logic [FC_W-1:0] nxt_fc;
  logic [PC_W-1:0] nxt_pc;

  assign start_hit   = (keycode[7:0]   == START_KEY) || (keycode[15:8]  == START_KEY) ||
                       (keycode[23:16] == START_KEY) || (keycode[31:24] == START_KEY);
  assign start_edge  = start_hit & ~start_prev;
  assign frame_wrap  = (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));
  assign pause_done  = (pause_cnt == PC_W'(GOAL_PAUSE_FRAMES - 1));
  assign win_reached = (score_p1 >= 4'(WIN_SCORE)) || (score_p2 >= 4'(WIN_SCORE));
  assign dec_time    = frame_wrap ? floor_dec(time_left) : time_left;

  // Counters default to zero so every state entry starts a fresh second.
  always_comb begin
    nxt_state = state;
    nxt_p1    = score_p1;
    nxt_p2    = score_p2;
    nxt_time  = time_left;
    nxt_cd    = 2'd0;
    nxt_fc    = '0;
    nxt_pc    = '0;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          nxt_state = S_KICKOFF;
          nxt_p1    = 4'd0;
          nxt_p2    = 4'd0;
          nxt_time  = 8'(MATCH_SECONDS);
          nxt_cd    = 2'(KICKOFF_SECONDS);
        end
      end
      S_KICKOFF: begin
        nxt_cd = countdown;
        nxt_fc = frame_wrap ? '0 : frame_cnt + 1'b1;
        if (frame_wrap) begin
          if (countdown <= 2'd1) begin
            nxt_state = S_PLAY;
            nxt_cd    = 2'd0;
          end else begin
            nxt_cd = countdown - 2'd1;
          end
        end
      end
      S_PLAY: begin
        nxt_fc   = frame_wrap ? '0 : frame_cnt + 1'b1;
        nxt_time = dec_time;
        // A goal wins over clock expiry in the same frame.
        if (goal_right) begin
          nxt_p1    = sat_inc(score_p1);
          nxt_state = S_GOAL;
          nxt_fc    = '0;
        end else if (goal_left) begin
          nxt_p2    = sat_inc(score_p2);
          nxt_state = S_GOAL;
          nxt_fc    = '0;
        end else if (dec_time == 8'd0) begin
          nxt_state = S_OVER;
          nxt_fc    = '0;
        end
      end
      S_GOAL: begin
        nxt_pc = pause_cnt + 1'b1;
        if (pause_done) begin
          nxt_pc = '0;
          if (win_reached || (time_left == 8'd0)) begin
            nxt_state = S_OVER;
          end else begin
            nxt_state = S_KICKOFF;
            nxt_cd    = 2'(KICKOFF_SECONDS);
          end
        end
      end
      S_OVER: begin
        if (start_edge) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Frame register: outputs reflect the state held for the coming frame.
  always_ff @(posedge frame_clk) begin
    start_prev <= Reset ? 1'b0 : start_hit;
    if (Reset) begin
      state      <= S_IDLE;
      char_reset <= 1'b1;
      ball_reset <= 1'b1;
      play_en    <= 1'b0;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      time_left  <= 8'(MATCH_SECONDS);
      countdown  <= 2'd0;
      frame_cnt  <= '0;
      pause_cnt  <= '0;
    end else begin
      state      <= nxt_state;
      char_reset <= (nxt_state == S_IDLE) || (nxt_state == S_KICKOFF);
      ball_reset <= (nxt_state == S_IDLE) || (nxt_state == S_KICKOFF);
      play_en    <= (nxt_state == S_PLAY);
      score_p1   <= nxt_p1;
      score_p2   <= nxt_p2;
      time_left  <= nxt_time;
      countdown  <= nxt_cd;
      frame_cnt  <= nxt_fc;
      pause_cnt  <= nxt_pc;
    end
  end

endmodule

// File: doc/match_controller.md
# match_controller

Game-flow sequencer for head-soccer: owns the match state machine, the match clock, the kickoff countdown and the score registers. Each character instance and the ball are held at spawn through `char_reset`/`ball_reset`, and ball motion is gated through `play_en`. The block runs on `frame_clk` (one tick per video frame), watches the shared 32-bit USB `keycode` for the start key, and takes goal strobes from the ball/goal-detect logic.

## Interface
- `FRAMES_PER_SEC`, 60, frames per match-clock second
- `MATCH_SECONDS`, 90, match length in seconds (≤255)
- `KICKOFF_SECONDS`, 3, kickoff countdown length (≤3)
- `GOAL_PAUSE_FRAMES`, 120, freeze length after a goal
- `WIN_SCORE`, 5, score that ends the match (≤15)
- `START_KEY`, 8'h28, HID usage code for the start key (Enter)
- `frame_clk`  in  1  sole clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `keycode`  in  32  four HID key bytes, any slot may hold `START_KEY`
- `goal_left`  in  1  ball fully inside left goal this frame (player 2 scores)
- `goal_right`  in  1  ball fully inside right goal this frame (player 1 scores)
- `char_reset`  out  1  hold both characters at spawn
- `ball_reset`  out  1  hold ball at center spawn
- `play_en`  out  1  ball physics enabled
- `score_p1`, `score_p2`  out  4  scores
- `time_left`  out  8  match seconds remaining
- `countdown`  out  2  kickoff seconds remaining (0 outside KICKOFF)
- `state`  out  3  IDLE=0, KICKOFF=1, PLAY=2, GOAL=3, OVER=4

## Operation
- `start_hit` = `START_KEY` present in any of the 4 bytes. `start_edge` = `start_hit` & ~`start_prev`. `start_prev` is registered every frame, including during Reset, where it clears to 0.
- IDLE: `char_reset`=`ball_reset`=1, `play_en`=0. On `start_edge`: clear scores, load `time_left`=`MATCH_SECONDS`, and go to KICKOFF.
- KICKOFF: `char_reset`=`ball_reset`=1, `play_en`=0. `countdown` loads `KICKOFF_SECONDS` on entry and decrements when `frame_cnt` wraps. On the wrap where `countdown`=1, go to PLAY; `countdown` reads 0 from that frame.
- PLAY: resets deasserted, `play_en`=1. `frame_cnt` runs; on wrap, `time_left` decrements.
  - `goal_right`: `score_p1`+1, then GOAL.
  - `goal_left` (when `goal_right`=0): `score_p2`+1, then GOAL. `goal_right` has priority if both are asserted; only one point is awarded.
  - Goal and clock expiry in the same frame: the goal counts, then GOAL.
  - Else `time_left` reaching 0: go to OVER.
- GOAL: `play_en`=0, resets deasserted. `pause_cnt` counts `GOAL_PAUSE_FRAMES` frames. At its end:
  - OVER if either score = `WIN_SCORE` or `time_left`=0;
  - else KICKOFF.
  - Goal inputs are ignored.
- OVER: `play_en`=0, resets deasserted, scores and time frozen. `start_edge` returns to IDLE. A further `start_edge` is needed to start the next match.
- Scores saturate at 15; `time_left` never wraps below 0.
- `frame_cnt` (6+ bits, 0..`FRAMES_PER_SEC`-1) clears on every state entry, so each second after entry is exactly `FRAMES_PER_SEC` frames.

## Timing
- All outputs are registered and reflect the state held during the current frame. There is no combinational input→output path.
- Reset values:
  - `state`=IDLE
  - `char_reset`=1, `ball_reset`=1, `play_en`=0
  - `score_p1`=`score_p2`=0
  - `time_left`=`MATCH_SECONDS`, `countdown`=0
  - `frame_cnt`=`pause_cnt`=0
- Reset mid-match aborts immediately to these values on the next edge.
- Latency:
  - `start_edge` in frame N → KICKOFF outputs at frame N+1.
  - Goal strobe in frame N → updated score and `state`=GOAL at frame N+1.
- KICKOFF lasts exactly `KICKOFF_SECONDS`×`FRAMES_PER_SEC` frames.
- GOAL lasts exactly `GOAL_PAUSE_FRAMES` frames.
- PLAY with no goals lasts `MATCH_SECONDS`×`FRAMES_PER_SEC` frames.
- A start key held continuously produces one `start_edge` only.

## Test plan
- Reset, then start key pressed in slot 3 for 10 frames → one transition to KICKOFF; `countdown` 3→2→1 at 60-frame steps; PLAY after exactly 180 frames with `play_en`=1 and resets low.
- In PLAY, pulse `goal_right` 1 frame → next frame `score_p1`=1, `state`=GOAL, `play_en`=0; KICKOFF after 120 frames, `time_left` unchanged during the pause.
- Assert `goal_left` and `goal_right` in the same frame → `score_p1`=1, `score_p2`=0.
- Drive 5 `goal_left` goals → after the 5th GOAL pause, `state`=OVER, `score_p2`=5; further goal pulses produce no change.
- No goals with `MATCH_SECONDS`=2 → OVER after 120 PLAY frames, `time_left`=0; start press → IDLE, a second start press → KICKOFF with scores 0.
- Assert `Reset` mid-PLAY with scores 3/2 → next frame IDLE, scores 0, `time_left`=90, `char_reset`=1.
